fb_write_arbiter: RTL and testbench

Frame-level arbiter and buffer-swap sequencer for the double-buffered 32x32 RGB LED frame memory. It shares the single back-buffer write port between two pattern generators (e.g. the dimmer and a host loader) and grants ownership for a whole frame. It muxes the owner's writes onto the frame memory and toggles `selected_buffer` when the owner finishes. It then waits for the display scanner to acknowledge via `actual_buffer` before re-arbitrating.

---
 rtl/fb_arb_pkg.sv | 28 ++
 rtl/fb_arb_watchdog.sv | 32 +++
 rtl/fb_write_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and widths for the frame-buffer write arbiter.
// Optional watchdog is enabled by defining FB_ARB_TIMEOUT_EN.
package fb_arb_pkg;

  localparam int unsigned FB_ADDR_W  = 11;
  localparam int unsigned FB_DATA_W  = 24;
  localparam int unsigned FB_NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OWN       = 2'd1,
    ST_SWAP      = 2'd2,
    ST_WAIT_DISP = 2'd3
  } fb_arb_state_e;

  // One frame-memory write beat: {row, col} address, {b, g, r} data, strobe.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
    logic                 ena;
  } fb_wr_s;

  // One-hot grant vector for a requester index.
  function automatic logic [FB_NUM_REQ-1:0] fb_onehot(input logic idx);
    fb_onehot = FB_NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/fb_arb_watchdog.sv
// Owner-inactivity watchdog: counts idle owner cycles, flags expiry combinationally.
// Only instantiated when FB_ARB_TIMEOUT_EN is defined.
module fb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Expire on the TIMEOUT_CYCLES-th consecutive cycle without an owner strobe.
  assign expire_c = run && !kick && (count == LIMIT);

  // Idle-cycle counter; cleared outside ownership, on a strobe, or on expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!run || kick || expire_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-level arbiter and buffer-swap sequencer for the double-buffered LED frame memory.
// Define FB_ARB_TIMEOUT_EN to build the owner-inactivity watchdog.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FB_NUM_REQ-1:0] req,
  input  logic [FB_NUM_REQ-1:0] done,
  input  logic [FB_ADDR_W-1:0]  r0_addr,
  input  logic [FB_DATA_W-1:0]  r0_data,
  input  logic                  r0_ena,
  input  logic [FB_ADDR_W-1:0]  r1_addr,
  input  logic [FB_DATA_W-1:0]  r1_data,
  input  logic                  r1_ena,
  output logic [FB_NUM_REQ-1:0] gnt,
  output logic [FB_ADDR_W-1:0]  wr_addr,
  output logic [FB_DATA_W-1:0]  wr_data,
  output logic                  wr_ena,
  output logic                  selected_buffer,
  input  logic                  actual_buffer,
  output logic                  drop_err,
  output logic                  timeout
);

  fb_arb_state_e         state_q, state_d;
  logic                  last_owner, last_owner_d;
  fb_wr_s                wr_q, wr_d;
  logic [FB_NUM_REQ-1:0] gnt_d;
  logic                  sel_d;
  logic                  drop_d;
  logic                  timeout_d;
  fb_wr_s                own_wr_c;
  logic                  other_ena_c;
  logic                  pick_c;
  logic                  expire_c;

  assign wr_addr = wr_q.addr;
  assign wr_data = wr_q.data;
  assign wr_ena  = wr_q.ena;

`ifdef FB_ARB_TIMEOUT_EN
  // Watchdog runs only while a requester owns the write port.
  fb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q == ST_OWN),
    .kick     (own_wr_c.ena),
    .expire_c (expire_c)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 32'd0);
  assign expire_c = 1'b0;
`endif

  // Select the owner's write beat and the other requester's strobe.
  always_comb begin
    own_wr_c    = '0;
    other_ena_c = 1'b0;
    if (last_owner) begin
      own_wr_c.addr = r1_addr;
      own_wr_c.data = r1_data;
      own_wr_c.ena  = r1_ena;
      other_ena_c   = r0_ena;
    end else begin
      own_wr_c.addr = r0_addr;
      own_wr_c.data = r0_data;
      own_wr_c.ena  = r0_ena;
      other_ena_c   = r1_ena;
    end
  end

  // Round-robin pick: on a tie the requester that did not own last wins.
  always_comb begin
    pick_c = 1'b0;
    if (req == 2'b11) begin
      pick_c = ~last_owner;
    end else begin
      pick_c = req[1];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner;
    wr_d         = wr_q;
    wr_d.ena     = 1'b0;
    gnt_d        = gnt;
    sel_d        = selected_buffer;
    drop_d       = drop_err;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (r0_ena || r1_ena) begin
          drop_d = 1'b1;
        end
        if (|req) begin
          last_owner_d = pick_c;
          gnt_d        = fb_onehot(pick_c);
          state_d      = ST_OWN;
        end
      end

      ST_OWN: begin
        if (own_wr_c.ena) begin
          wr_d = own_wr_c;
        end
        if (other_ena_c) begin
          drop_d = 1'b1;
        end
        if (done[last_owner]) begin
          gnt_d   = '0;
          state_d = ST_SWAP;
        end else if (!req[last_owner]) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end else if (expire_c) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_SWAP: begin
        if (r0_ena || r1_ena) begin
          drop_d = 1'b1;
        end
        sel_d   = ~selected_buffer;
        state_d = ST_WAIT_DISP;
      end

      ST_WAIT_DISP: begin
        if (r0_ena || r1_ena) begin
          drop_d = 1'b1;
        end
        if (actual_buffer == selected_buffer) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      last_owner      <= 1'b1;
      wr_q            <= '0;
      gnt             <= '0;
      selected_buffer <= 1'b0;
      drop_err        <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_owner      <= last_owner_d;
      wr_q            <= wr_d;
      gnt             <= gnt_d;
      selected_buffer <= sel_d;
      drop_err        <= drop_d;
      timeout         <= timeout_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter.
// With FB_ARB_TIMEOUT_EN defined it also exercises the watchdog (TIMEOUT_CYCLES = 8).
`timescale 1ns/1ps
module tb_fb_write_arbiter;
  import fb_arb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [FB_NUM_REQ-1:0] req = '0;
  logic [FB_NUM_REQ-1:0] done = '0;
  logic [FB_ADDR_W-1:0]  r0_addr = '0;
  logic [FB_DATA_W-1:0]  r0_data = '0;
  logic                  r0_ena = 1'b0;
  logic [FB_ADDR_W-1:0]  r1_addr = '0;
  logic [FB_DATA_W-1:0]  r1_data = '0;
  logic                  r1_ena = 1'b0;
  logic                  actual_buffer = 1'b0;
  logic [FB_NUM_REQ-1:0] gnt;
  logic [FB_ADDR_W-1:0]  wr_addr;
  logic [FB_DATA_W-1:0]  wr_data;
  logic                  wr_ena;
  logic                  selected_buffer;
  logic                  drop_err;
  logic                  timeout;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fb_write_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .done            (done),
    .r0_addr         (r0_addr),
    .r0_data         (r0_data),
    .r0_ena          (r0_ena),
    .r1_addr         (r1_addr),
    .r1_data         (r1_data),
    .r1_ena          (r1_ena),
    .gnt             (gnt),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ena          (wr_ena),
    .selected_buffer (selected_buffer),
    .actual_buffer   (actual_buffer),
    .drop_err        (drop_err),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"},      32'(gnt),             32'h0);
    check({tag, " wr_addr"},  32'(wr_addr),         32'h0);
    check({tag, " wr_data"},  32'(wr_data),         32'h0);
    check({tag, " wr_ena"},   32'(wr_ena),          32'h0);
    check({tag, " sel_buf"},  32'(selected_buffer), 32'h0);
    check({tag, " drop_err"}, 32'(drop_err),        32'h0);
    check({tag, " timeout"},  32'(timeout),         32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    // Reset
    #2 rst = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b1;
    step();
    check("idle_gnt", 32'(gnt), 32'h0);

    // Tie after reset: requester 0 wins
    req = 2'b11;
    step();
    check("first_tie_gnt", 32'(gnt), 32'h1);

    // Owner write passes through with one-cycle latency
    r0_addr = 11'h3FF;
    r0_data = 24'h00FF00;
    r0_ena  = 1'b1;
    step();
    check("wr_ena_pulse", 32'(wr_ena),  32'h1);
    check("wr_addr_3ff",  32'(wr_addr), 32'h3FF);
    check("wr_data_ff00", 32'(wr_data), 32'h00FF00);
    r0_ena = 1'b0;
    step();
    check("wr_ena_single", 32'(wr_ena),   32'h0);
    check("drop_err_none", 32'(drop_err), 32'h0);

    // Non-owner strobe dropped, drop_err sticky
    r1_addr = 11'h155;
    r1_data = 24'hAA55AA;
    r1_ena  = 1'b1;
    step();
    check("nonowner_wr_ena", 32'(wr_ena),   32'h0);
    check("drop_err_set",    32'(drop_err), 32'h1);
    r1_ena = 1'b0;
    step();
    check("drop_err_sticky", 32'(drop_err), 32'h1);
    check("still_owner",     32'(gnt),      32'h1);

    // Done together with a final owner write, actual_buffer = 0
    r0_addr = 11'h123;
    r0_data = 24'hABCDEF;
    r0_ena  = 1'b1;
    done    = 2'b01;
    step();
    check("swap_gnt_clear",  32'(gnt),             32'h0);
    check("done_wr_ena",     32'(wr_ena),          32'h1);
    check("done_wr_addr",    32'(wr_addr),         32'h123);
    check("done_wr_data",    32'(wr_data),         32'hABCDEF);
    check("swap_sel_before", 32'(selected_buffer), 32'h0);
    r0_ena = 1'b0;
    done   = 2'b00;
    step();
    check("sel_toggled", 32'(selected_buffer), 32'h1);
    check("wait_gnt0",   32'(gnt),             32'h0);
    step();
    step();
    check("wait_held_gnt0", 32'(gnt), 32'h0);
    actual_buffer = 1'b1;
    step();
    check("wait_to_idle_gnt0", 32'(gnt), 32'h0);
    step();
    check("rr_tie_gnt_r1", 32'(gnt), 32'h2);

    // Owner r1 aborts: no swap
    req = 2'b01;
    step();
    check("abort_gnt0",    32'(gnt),             32'h0);
    check("abort_sel_kept", 32'(selected_buffer), 32'h1);
    step();
    check("regrant_r0", 32'(gnt), 32'h1);

`ifdef FB_ARB_TIMEOUT_EN
    // Owner idle: timeout on the 8th idle cycle
    for (int i = 0; i < 7; i++) begin
      step();
      check("pre_timeout", 32'(timeout), 32'h0);
    end
    step();
    check("timeout_pulse", 32'(timeout),         32'h1);
    check("timeout_gnt0",  32'(gnt),             32'h0);
    check("timeout_noswap", 32'(selected_buffer), 32'h1);
    step();
    check("timeout_single", 32'(timeout), 32'h0);
    check("timeout_regrant", 32'(gnt),   32'h1);
`else
    // Without the watchdog, an idle owner keeps ownership
    for (int i = 0; i < 20; i++) begin
      step();
    end
    check("no_timeout",     32'(timeout), 32'h0);
    check("idle_owner_gnt", 32'(gnt),     32'h1);
`endif

    // Minimum turnaround: actual_buffer already matches after the toggle
    done          = 2'b01;
    actual_buffer = 1'b0;
    step();
    check("turn_c1_gnt", 32'(gnt), 32'h0);
    done = 2'b00;
    step();
    check("turn_c2_gnt", 32'(gnt),             32'h0);
    check("turn_c2_sel", 32'(selected_buffer), 32'h0);
    step();
    check("turn_c3_gnt", 32'(gnt), 32'h0);
    step();
    check("turn_c4_gnt", 32'(gnt), 32'h1);

    // Mid-frame write with bit 10 set, then asynchronous reset
    r0_addr = 11'h7AA;
    r0_data = 24'h123456;
    r0_ena  = 1'b1;
    step();
    check("bit10_wr_addr", 32'(wr_addr), 32'h7AA);
    check("bit10_wr_data", 32'(wr_data), 32'h123456);
    #3 rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    r0_ena = 1'b0;
    step();
    check_all_zero("held_rst");
    rst = 1'b1;
    req = 2'b11;
    step();
    check("post_rst_tie_r0", 32'(gnt), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
